// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of unsigned products and presents each group result over a valid/ready handshake
module product_accumulator #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_TERMS = 16,
  localparam int PW = WIDTH_A + WIDTH_B,
  localparam int CNT_W = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        in_prod,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);
  if (ACC_WIDTH < PW) begin : g_bad_width
    $error("ACC_WIDTH must be at least WIDTH_A+WIDTH_B");
  end
  if (MAX_TERMS < 1) begin : g_bad_terms
    $error("MAX_TERMS must be at least 1");
  end
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic ovf_acc;
  logic [ACC_WIDTH:0] sum;
  logic [CNT_W-1:0] new_count;
  logic new_ovf, close;
  assign in_ready = state == ACCUM;
  assign sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - PW){1'b0}}, in_prod};
  assign new_count = count + 1'b1;
  assign new_ovf = ovf_acc | sum[ACC_WIDTH];
  assign close = in_last || new_count == CNT_W'(MAX_TERMS);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      count <= '0;
      ovf_acc <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_count <= '0;
      out_ovf <= 1'b0;
    end else if (state == ACCUM) begin
      if (in_valid && close) begin
        out_sum <= sum[ACC_WIDTH-1:0];
        out_count <= new_count;
        out_ovf <= new_ovf;
        out_valid <= 1'b1;
        state <= HOLD;
        acc <= '0;
        count <= '0;
        ovf_acc <= 1'b0;
      end else if (in_valid) begin
        acc <= sum[ACC_WIDTH-1:0];
        count <= new_count;
        ovf_acc <= new_ovf;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      state <= ACCUM;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks of grouping, backpressure, auto-close, overflow, reset and gaps
module tb_product_accumulator;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_prod = 0;
  logic in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [4:0] out_count;
  logic v_in_valid = 0, v_in_last = 0, v_out_ready = 1;
  logic [7:0] v_in_prod = 0;
  logic v_in_ready, v_out_valid, v_out_ovf;
  logic [9:0] v_out_sum;
  logic [4:0] v_out_count;
  int errors = 0, checks = 0;

  product_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  product_accumulator #(.ACC_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready), .in_prod(v_in_prod),
    .in_last(v_in_last), .out_valid(v_out_valid), .out_ready(v_out_ready), .out_sum(v_out_sum),
    .out_count(v_out_count), .out_ovf(v_out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] p, input logic l);
    in_valid = 1;
    in_prod = p;
    in_last = l;
    step();
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic vbeat(input logic [7:0] p, input logic l);
    v_in_valid = 1;
    v_in_prod = p;
    v_in_last = l;
    step();
    v_in_valid = 0;
    v_in_last = 0;
  endtask

  initial begin
    step();
    step();
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_ready", in_ready, 1);
    // basic three-beat group, consumed immediately
    beat(8'h0F, 0);
    beat(8'h10, 0);
    chk("t1_not_yet", out_valid, 0);
    beat(8'h01, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_sum", out_sum, 16'h0020);
    chk("t1_count", out_count, 3);
    chk("t1_ovf", out_ovf, 0);
    chk("t1_ready_low", in_ready, 0);
    step();
    chk("t1_consumed", out_valid, 0);
    chk("t1_ready_back", in_ready, 1);
    chk("t1_sum_kept", out_sum, 16'h0020);
    // backpressure, with junk beats offered during HOLD
    out_ready = 0;
    beat(8'h0F, 0);
    beat(8'h10, 0);
    beat(8'h01, 1);
    in_valid = 1;
    in_prod = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", out_valid, 1);
      chk("t2_ready", in_ready, 0);
      chk("t2_sum", out_sum, 16'h0020);
      chk("t2_count", out_count, 3);
      step();
    end
    in_valid = 0;
    out_ready = 1;
    step();
    chk("t2_released", out_valid, 0);
    chk("t2_ready_back", in_ready, 1);
    // auto-close at MAX_TERMS
    for (int i = 0; i < 15; i++) beat(8'hE1, 0);
    chk("t3_open", out_valid, 0);
    beat(8'hE1, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_sum", out_sum, 16'h0E10);
    chk("t3_count", out_count, 16);
    chk("t3_ovf", out_ovf, 0);
    step();
    beat(8'h02, 1);
    chk("t3_next_count", out_count, 1);
    chk("t3_next_sum", out_sum, 16'h0002);
    step();
    // overflow on the 10-bit accumulator
    for (int i = 0; i < 4; i++) vbeat(8'hFF, 0);
    vbeat(8'hFF, 1);
    chk("t4_valid", v_out_valid, 1);
    chk("t4_sum", v_out_sum, 251);
    chk("t4_count", v_out_count, 5);
    chk("t4_ovf", v_out_ovf, 1);
    step();
    vbeat(8'h01, 1);
    chk("t4_next_sum", v_out_sum, 1);
    chk("t4_next_ovf", v_out_ovf, 0);
    step();
    // reset mid-group, then reset during HOLD
    beat(8'h40, 0);
    beat(8'h40, 0);
    rst = 1;
    step();
    rst = 0;
    chk("t5_rst_valid", out_valid, 0);
    beat(8'h05, 1);
    chk("t5_sum", out_sum, 16'h0005);
    chk("t5_count", out_count, 1);
    out_ready = 0;
    step();
    chk("t5_holding", out_valid, 1);
    rst = 1;
    step();
    rst = 0;
    chk("t5_hold_rst_valid", out_valid, 0);
    chk("t5_hold_rst_ready", in_ready, 1);
    chk("t5_hold_rst_sum", out_sum, 0);
    out_ready = 1;
    // gapped input with junk on idle cycles
    beat(8'hFF, 0);
    in_prod = 8'hAA;
    in_last = 1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_gap_idle", out_valid, 0);
    beat(8'h01, 1);
    chk("t6_valid", out_valid, 1);
    chk("t6_sum", out_sum, 16'h0100);
    chk("t6_count", out_count, 2);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
